// File: rtl/dev_command_parser.sv
// rtl/dev_command_parser.sv - host UART command frame parser with paced data FIFO
// Optional trailing-checksum support is enabled by defining DEV_CMD_PARSER_CHECKSUM_EN.
module dev_command_parser #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_byte_received,
  input  logic [7:0] uart_rx_byte,
  output logic       dev_command_started,
  output logic       dev_command_processing,
  output logic [4:0] dev_command,
  input  logic       dev_busy,
  output logic       dev_command_data_signal,
  output logic [7:0] dev_data,
  output logic       frame_error,
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
  output logic       overflow_error,
  output logic       checksum_error
`else
  output logic       overflow_error
`endif
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_LEN = 3'd1,
    S_START   = 3'd2,
    S_DATA    = 3'd3,
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
    S_CHECK   = 3'd5,
`endif
    S_DONE    = 3'd4
  } state_t;

`ifdef DEV_CMD_PARSER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHECK;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t          state, state_next;
  logic [7:0]      len;
  logic [7:0]      rx_cnt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   idle_cnt;
  logic            push, pop, drop, stray, idle_run, timeout_hit;
  logic            rx_more, fifo_empty, fifo_full;
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
  logic [7:0]      chk_acc;
  logic            chk_got, chk_take;
`endif

  assign rx_more             = rx_cnt < len;
  assign fifo_empty          = count == '0;
  assign fifo_full           = count == CW'(FIFO_DEPTH);
  assign dev_command_started = state == S_START;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    push        = 1'b0;
    drop        = 1'b0;
    pop         = 1'b0;
    stray       = 1'b0;
    idle_run    = 1'b0;
    timeout_hit = 1'b0;
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
    chk_take    = 1'b0;
`endif
    case (state)
      S_IDLE: if (uart_rx_byte_received && uart_rx_byte[7]) state_next = S_GET_LEN;
      S_GET_LEN: begin
        idle_run = 1'b1;
        if (uart_rx_byte_received) state_next = S_START;
      end
      S_START: begin
        stray      = uart_rx_byte_received;
        state_next = (len == 8'd0) ? S_AFTER_DATA : S_DATA;
      end
      S_DATA: begin
        idle_run = rx_more;
        if (uart_rx_byte_received && rx_more) begin
          if (fifo_full) drop = 1'b1;
          else           push = 1'b1;
        end
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
        // The checksum may arrive while the device is still draining the FIFO.
        if (uart_rx_byte_received && !rx_more && !chk_got) chk_take = 1'b1;
`endif
        pop = !fifo_empty && !dev_busy && !dev_command_data_signal;
        if (!rx_more && fifo_empty) state_next = S_AFTER_DATA;
      end
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
      S_CHECK: begin
        idle_run = !chk_got;
        if (chk_got) begin
          state_next = S_DONE;
        end else if (uart_rx_byte_received) begin
          chk_take   = 1'b1;
          state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        stray = uart_rx_byte_received;
        if (!dev_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (TIMEOUT_CYCLES != 0 && idle_run && !uart_rx_byte_received &&
        idle_cnt == TW'(TO_LAST)) begin
      timeout_hit = 1'b1;
      pop         = 1'b0;
      state_next  = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= uart_rx_byte;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dev_command             <= '0;
      dev_command_processing  <= 1'b0;
      dev_command_data_signal <= 1'b0;
      dev_data                <= '0;
      frame_error             <= 1'b0;
      overflow_error          <= 1'b0;
      len                     <= '0;
      rx_cnt                  <= '0;
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      count                   <= '0;
      idle_cnt                <= '0;
    end else begin
      frame_error             <= stray || timeout_hit;
      overflow_error          <= drop;
      dev_command_data_signal <= pop;
      if (state == S_IDLE && uart_rx_byte_received && uart_rx_byte[7])
        dev_command <= uart_rx_byte[4:0];
      if (state == S_GET_LEN && uart_rx_byte_received) begin
        len    <= uart_rx_byte;
        rx_cnt <= '0;
      end
      // Dropped bytes still count toward the frame so it can terminate.
      if (push || drop) rx_cnt <= rx_cnt + 8'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        dev_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (uart_rx_byte_received || !idle_run || timeout_hit) idle_cnt <= '0;
      else                                                 idle_cnt <= idle_cnt + TW'(1);
      if (timeout_hit || (state == S_DONE && !dev_busy)) dev_command_processing <= 1'b0;
      else if (state == S_START)                         dev_command_processing <= 1'b1;
      if (timeout_hit) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end
    end
  end

`ifdef DEV_CMD_PARSER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chk_acc        <= '0;
      chk_got        <= 1'b0;
      checksum_error <= 1'b0;
    end else begin
      checksum_error <= chk_take && (uart_rx_byte != chk_acc);
      if (state == S_IDLE && uart_rx_byte_received && uart_rx_byte[7])
        chk_acc <= uart_rx_byte;
      else if ((state == S_GET_LEN && uart_rx_byte_received) || push || drop)
        chk_acc <= chk_acc ^ uart_rx_byte;
      if (state == S_GET_LEN) chk_got <= 1'b0;
      else if (chk_take)      chk_got <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dev_command_parser.sv
// tb/tb_dev_command_parser.sv - directed bench for dev_command_parser
// Two instances share stimulus: dut_a (FIFO 16) and dut_b (FIFO 4), both with a 100-clock timeout.
module tb_dev_command_parser;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_stb;
  logic [7:0] rx_byte;
  logic       busy;

  logic       started_a, proc_a, sig_a, ferr_a, ovf_a;
  logic [4:0] cmd_a;
  logic [7:0] data_a;
  logic       started_b, proc_b, sig_b, ferr_b, ovf_b;
  logic [4:0] cmd_b;
  logic [7:0] data_b;
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
  logic       cerr_a, cerr_b;
`endif

  dev_command_parser #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(100)) dut_a (
    .clock(clock), .reset(reset),
    .uart_rx_byte_received(rx_stb), .uart_rx_byte(rx_byte),
    .dev_command_started(started_a), .dev_command_processing(proc_a),
    .dev_command(cmd_a), .dev_busy(busy),
    .dev_command_data_signal(sig_a), .dev_data(data_a),
    .frame_error(ferr_a),
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
    .overflow_error(ovf_a), .checksum_error(cerr_a)
`else
    .overflow_error(ovf_a)
`endif
  );

  dev_command_parser #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut_b (
    .clock(clock), .reset(reset),
    .uart_rx_byte_received(rx_stb), .uart_rx_byte(rx_byte),
    .dev_command_started(started_b), .dev_command_processing(proc_b),
    .dev_command(cmd_b), .dev_busy(busy),
    .dev_command_data_signal(sig_b), .dev_data(data_b),
    .frame_error(ferr_b),
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
    .overflow_error(ovf_b), .checksum_error(cerr_b)
`else
    .overflow_error(ovf_b)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         ta[$];
  int n_ovf_a = 0, n_ovf_b = 0, n_ferr_a = 0, n_st_a = 0, n_cerr_a = 0;

  always @(negedge clock) begin
    if (sig_a) begin qa.push_back(data_a); ta.push_back(cyc); end
    if (sig_b) qb.push_back(data_b);
    if (ovf_a) n_ovf_a++;
    if (ovf_b) n_ovf_b++;
    if (ferr_a) n_ferr_a++;
    if (started_a) n_st_a++;
`ifdef DEV_CMD_PARSER_CHECKSUM_EN
    if (cerr_a) n_cerr_a++;
`endif
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clock); #1;
    rx_stb  = 1'b1;
    rx_byte = b;
    @(posedge clock); #1;
    rx_stb  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_ferr(output int k);
    k = 0;
    for (int i = 1; i <= 200 && k == 0; i++) begin
      @(posedge clock); #1;
      if (ferr_a) k = i;
    end
  endtask

  int ba, bb, bo, bf, bs, k;
  logic [7:0] exp_b;

  initial begin
    reset = 1'b1; rx_stb = 1'b0; rx_byte = 8'h00; busy = 1'b0;
    idle(3);
    check("rst_started", started_a, 0);
    check("rst_processing", proc_a, 0);
    check("rst_command", cmd_a, 0);
    check("rst_data_signal", sig_a, 0);
    check("rst_data", data_a, 0);
    check("rst_errors", {ferr_a, ovf_a, ferr_b, ovf_b}, 0);
    reset = 1'b0;
    idle(2);

`ifdef DEV_CMD_PARSER_CHECKSUM_EN
    ba = qa.size();
    send(8'h81); send(8'h02); send(8'h10); send(8'h20); send(8'hB3);
    idle(8);
    check("cks_good_err", n_cerr_a, 0);
    check("cks_good_data", qa.size() - ba, 2);
    check("cks_good_proc", proc_a, 0);
    send(8'h81); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    idle(8);
    check("cks_bad_err", n_cerr_a, 1);
    check("cks_bad_data", qa.size() - ba, 4);
    check("cks_bad_frame_err", n_ferr_a, 0);
    check("cks_bad_proc", proc_a, 0);
`else
    // zero-length frame
    send(8'h81); send(8'h00);
    check("t1_started", started_a, 1);
    check("t1_proc_at_start", proc_a, 0);
    check("t1_command", cmd_a, 5'd1);
    idle(1);
    check("t1_started_gone", started_a, 0);
    check("t1_proc_high", proc_a, 1);
    idle(1);
    check("t1_proc_low", proc_a, 0);

    // three data bytes, device ready
    ba = qa.size();
    send(8'h82); send(8'h03); send(8'h11); send(8'hA2); send(8'h33);
    idle(10);
    check("t2_count", qa.size() - ba, 3);
    check("t2_d0", qa[ba], 8'h11);
    check("t2_d1", qa[ba+1], 8'hA2);
    check("t2_d2", qa[ba+2], 8'h33);
    check("t2_command", cmd_a, 5'd2);
    check("t2_proc", proc_a, 0);

    // device busy through a 5-byte frame, bytes with bit7 set are data
    ba = qa.size(); bo = n_ovf_a;
    busy = 1'b1;
    send(8'h83); send(8'h05);
    for (int i = 1; i <= 5; i++) send(8'hC0 + 8'(i));
    idle(1);
    check("t3_held", qa.size() - ba, 0);
    check("t3_proc_busy", proc_a, 1);
    busy = 1'b0;
    idle(20);
    check("t3_count", qa.size() - ba, 5);
    for (int i = 0; i < 5; i++) check("t3_data", qa[ba+i], 8'hC1 + 8'(i));
    for (int i = 0; i < 4; i++) check("t3_gap_ge2", (ta[ba+i+1] - ta[ba+i]) >= 2, 1);
    check("t3_no_overflow", n_ovf_a - bo, 0);
    check("t3_proc_end", proc_a, 0);

    // FIFO_DEPTH=4 overflow on bytes 5 and 6
    bb = qb.size(); bo = n_ovf_b;
    busy = 1'b1;
    send(8'h84); send(8'h06);
    for (int i = 1; i <= 4; i++) send(8'(i));
    idle(1);
    check("t4_ovf_before", n_ovf_b - bo, 0);
    send(8'h05); send(8'h06);
    idle(1);
    check("t4_ovf_after", n_ovf_b - bo, 2);
    check("t4_held", qb.size() - bb, 0);
    busy = 1'b0;
    idle(20);
    check("t4_count", qb.size() - bb, 4);
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'(i + 1);
      check("t4_data", qb[bb+i], exp_b);
    end
    check("t4_proc_end", proc_b, 0);

    // timeout inside DATA: 2 of 4 bytes then silence
    ba = qa.size();
    send(8'h81); send(8'h04); send(8'hAA); send(8'hBB);
    wait_ferr(k);
    check("t5_timeout_clocks", k, 100);
    check("t5_proc", proc_a, 0);
    check("t5_delivered", qa.size() - ba, 2);
    check("t5_last_data", qa[qa.size()-1], 8'hBB);

    // timeout in GET_LEN: no started pulse
    bs = n_st_a;
    send(8'h85);
    wait_ferr(k);
    check("t5b_timeout_clocks", k, 100);
    check("t5b_no_started", n_st_a - bs, 0);
    check("t5b_proc", proc_a, 0);

    // stray byte while DONE waits on dev_busy
    busy = 1'b1;
    send(8'h86); send(8'h00);
    idle(2);
    check("t6_proc_hold", proc_a, 1);
    bf = n_ferr_a;
    send(8'h55);
    idle(1);
    check("t6_frame_err", n_ferr_a - bf, 1);
    check("t6_proc_still", proc_a, 1);
    busy = 1'b0;
    idle(2);
    check("t6_proc_end", proc_a, 0);

    // resync: bit7=0 byte in IDLE is ignored
    ba = qa.size(); bs = n_st_a;
    send(8'h12); send(8'h87); send(8'h01); send(8'h99);
    idle(6);
    check("t7_command", cmd_a, 5'd7);
    check("t7_started", n_st_a - bs, 1);
    check("t7_count", qa.size() - ba, 1);
    check("t7_data", qa[ba], 8'h99);

    // reset mid-frame aborts silently
    busy = 1'b1;
    send(8'h88); send(8'h03); send(8'h01);
    reset = 1'b1;
    idle(1);
    check("t8_proc", proc_a, 0);
    check("t8_command", cmd_a, 0);
    ba = qa.size(); bf = n_ferr_a;
    reset = 1'b0; busy = 1'b0;
    idle(10);
    check("t8_no_pulses", qa.size() - ba, 0);
    check("t8_no_frame_err", n_ferr_a - bf, 0);
    send(8'h81); send(8'h01); send(8'h5A);
    idle(6);
    check("t8_after_data", qa[qa.size()-1], 8'h5A);
    check("t8_after_proc", proc_a, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
